muldiv_unit: RTL and testbench

//   Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_abs.sv | 19 +
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the quotient returned on divide-by-zero.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

    // All-ones quotient on divide-by-zero; sliced to the unit's width.
    localparam logic [63:0] MD_DIV0_Q = {64{1'b1}};

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: takes the magnitude of a signed operand,
// or flips the sign of an unsigned result when i_flip is set.
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_signed,
    input  logic             i_flip,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_sign
);

    logic w_neg;

    assign o_sign = i_signed & i_val[WIDTH-1];
    assign w_neg  = o_sign ^ i_flip;
    assign o_mag  = w_neg ? (-i_val) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes.
// Optional MULDIV_DIV0_FLAG_EN adds a sticky div0 output for divide-by-zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_is_div;
    logic               r_bzero;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_a_sign;
    logic               w_b_sign;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_res_sign;
    logic               w_rem_sign;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_unused;

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_val(A), .i_signed(~Op[0]), .i_flip(1'b0), .o_mag(w_a_mag), .o_sign(w_a_sign)
    );
    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_val(B), .i_signed(~Op[0]), .i_flip(1'b0), .o_mag(w_b_mag), .o_sign(w_b_sign)
    );
    // Result correction: low half of a 2W negate equals negating the quotient alone.
    muldiv_abs #(.WIDTH(2*WIDTH)) u_abs_res (
        .i_val(r_acc), .i_signed(1'b0), .i_flip(r_sign_q), .o_mag(w_res), .o_sign(w_res_sign)
    );
    muldiv_abs #(.WIDTH(WIDTH)) u_abs_rem (
        .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_signed(1'b0), .i_flip(r_sign_r),
        .o_mag(w_rem_fix), .o_sign(w_rem_sign)
    );

    // Multiply step: acc = {partial, multiplier}; add multiplicand then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_div_next = w_diff[WIDTH+1] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_unused = ^{w_diff[WIDTH], w_res_sign, w_rem_sign};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_is_div <= 1'b0;
            r_bzero  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (we_hi) r_hi <= wdata;
                    if (we_lo) r_lo <= wdata;
                    if (start || we_hi || we_lo) r_div0 <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_cnt    <= '0;
                        r_is_div <= Op[1];
                        r_b      <= Op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (Op[1] ? w_a_mag : w_b_mag)};
                        r_sign_q <= w_a_sign ^ w_b_sign;
                        r_sign_r <= w_a_sign;
                        r_bzero  <= (B == '0);
                        r_busy   <= 1'b1;
                        r_state  <= Op[1] ? S_DIV : S_MUL;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= (r_state == S_DIV) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= r_bzero ? MD_DIV0_Q[WIDTH-1:0] : w_res[WIDTH-1:0];
                        r_hi <= w_rem_fix;
                    end else begin
                        r_lo <= w_res[WIDTH-1:0];
                        r_hi <= w_res[2*WIDTH-1:WIDTH];
                    end
                    r_div0  <= r_is_div & r_bzero;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

`ifdef MULDIV_DIV0_FLAG_EN
    assign div0 = r_div0;
`else
    logic w_unused_div0;
    assign w_unused_div0 = r_div0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; define MULDIV_DIV0_FLAG_EN to
// also exercise the div0 flag.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Op(Op), .A(A), .B(B),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
`ifdef MULDIV_DIV0_FLAG_EN
        , .div0(div0)
`endif
    );

    // Launches one op from a point #1 after an edge; returns the cycle index of
    // done (cycle 1 = first cycle after the start edge) and the busy-cycle count.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", HI); end
        total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", LO); end
        $display("reset: busy=%b done=%b HI=%h LO=%h", busy, done, HI, LO);
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        $display("MULTU FFFFFFFF*FFFFFFFF: lat=%0d HI=%h LO=%h", lat, HI, LO);
        total++; if (lat != 34) begin bad++; $display("FAIL multu_latency got=%0d want=34", lat); end
        total++; if (HI !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h want=FFFFFFFE", HI); end
        total++; if (LO !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", LO); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done got=%b want=0", busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_mult();
        int lat, bc;
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, lat, bc);
        $display("MULT -3*7: lat=%0d busy_cycles=%0d HI=%h LO=%h", lat, bc, HI, LO);
        total++; if (bc != 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d want=33", bc); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=FFFFFFFF", HI); end
        total++; if (LO !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got=%h want=FFFFFFEB", LO); end
        @(posedge clk); #1;
        run_op(2'b00, 32'h80000000, 32'h80000000, lat, bc);
        $display("MULT 80000000*80000000: HI=%h LO=%h", HI, LO);
        total++; if (HI !== 32'h40000000) begin bad++; $display("FAIL mult_minint_hi got=%h want=40000000", HI); end
        total++; if (LO !== 32'h00000000) begin bad++; $display("FAIL mult_minint_lo got=%h want=00000000", LO); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, bc);
        $display("DIV -7/2: HI=%h LO=%h", HI, LO);
        total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=FFFFFFFD", LO); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=FFFFFFFF", HI); end
        // Launched directly from the DONE cycle.
        run_op(2'b11, 32'h00000007, 32'h00000002, lat, bc);
        $display("DIVU 7/2 from DONE: lat=%0d HI=%h LO=%h", lat, HI, LO);
        total++; if (lat != 34) begin bad++; $display("FAIL divu_b2b_latency got=%0d want=34", lat); end
        total++; if (LO !== 32'h00000003) begin bad++; $display("FAIL divu_lo got=%h want=00000003", LO); end
        total++; if (HI !== 32'h00000001) begin bad++; $display("FAIL divu_hi got=%h want=00000001", HI); end
    endtask

    task automatic test_div_special();
        int lat, bc;
        @(posedge clk); #1;
        run_op(2'b11, 32'h00000064, 32'h00000000, lat, bc);
        $display("DIVU 64/0: lat=%0d HI=%h LO=%h", lat, HI, LO);
        total++; if (lat != 34) begin bad++; $display("FAIL div0_latency got=%0d want=34", lat); end
        total++; if (LO !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo got=%h want=FFFFFFFF", LO); end
        total++; if (HI !== 32'h00000064) begin bad++; $display("FAIL div0_hi got=%h want=00000064", HI); end
`ifdef MULDIV_DIV0_FLAG_EN
        total++; if (div0 !== 1'b1) begin bad++; $display("FAIL div0_flag_set got=%b want=1", div0); end
`endif
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        $display("DIV 80000000/FFFFFFFF: HI=%h LO=%h", HI, LO);
        total++; if (LO !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo got=%h want=80000000", LO); end
        total++; if (HI !== 32'h00000000) begin bad++; $display("FAIL div_ovf_hi got=%h want=00000000", HI); end
`ifdef MULDIV_DIV0_FLAG_EN
        total++; if (div0 !== 1'b0) begin bad++; $display("FAIL div0_flag_clear got=%b want=0", div0); end
`endif
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000000, lat, bc);
        $display("DIV -7/0: HI=%h LO=%h", HI, LO);
        total++; if (LO !== 32'hFFFFFFFF) begin bad++; $display("FAIL sdiv0_lo got=%h want=FFFFFFFF", LO); end
        total++; if (HI !== 32'hFFFFFFF9) begin bad++; $display("FAIL sdiv0_hi got=%h want=FFFFFFF9", HI); end
    endtask

    task automatic test_busy_ignore();
        int n, ndone, lat;
        logic [31:0] h0;
        @(posedge clk); #1;
        h0 = HI;
        start = 1'b1; Op = 2'b01; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; ndone = 0; lat = 0;
        while (n < 60) begin
            if (n == 5) begin
                start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd3;
                we_hi = 1'b1; wdata = 32'h12345678;
            end
            @(posedge clk); #1;
            n++;
            if (n == 6) begin
                start = 1'b0; we_hi = 1'b0;
                total++; if (HI !== h0) begin bad++; $display("FAIL busy_write_hi got=%h want=%h", HI, h0); end
            end
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
        end
        $display("busy ignore: dones=%0d lat=%0d HI=%h LO=%h", ndone, lat, HI, LO);
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_start_dones got=%0d want=1", ndone); end
        total++; if (lat != 34) begin bad++; $display("FAIL busy_start_latency got=%0d want=34", lat); end
        total++; if (LO !== 32'h0000002A) begin bad++; $display("FAIL busy_start_lo got=%h want=0000002A", LO); end
        total++; if (HI !== 32'h00000000) begin bad++; $display("FAIL busy_start_hi got=%h want=00000000", HI); end
        we_hi = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1;
        we_hi = 1'b0;
        $display("idle MTHI 12345678: HI=%h LO=%h", HI, LO);
        total++; if (HI !== 32'h12345678) begin bad++; $display("FAIL idle_write_hi got=%h want=12345678", HI); end
        total++; if (LO !== 32'h0000002A) begin bad++; $display("FAIL idle_write_lo_kept got=%h want=0000002A", LO); end
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hA5A5C3C3;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0;
        $display("idle MTHI+MTLO A5A5C3C3: HI=%h LO=%h", HI, LO);
        total++; if (HI !== 32'hA5A5C3C3) begin bad++; $display("FAIL dual_write_hi got=%h want=A5A5C3C3", HI); end
        total++; if (LO !== 32'hA5A5C3C3) begin bad++; $display("FAIL dual_write_lo got=%h want=A5A5C3C3", LO); end
    endtask

    task automatic test_mid_reset();
        int n, lat, bc;
        start = 1'b1; Op = 2'b10; A = 32'hFFFFFFF9; B = 32'h00000002;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("mid reset: busy=%b done=%b HI=%h LO=%h", busy, done, HI, LO);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL midrst_hi got=%h want=00000000", HI); end
        total++; if (LO !== 32'h0) begin bad++; $display("FAIL midrst_lo got=%h want=00000000", LO); end
        run_op(2'b01, 32'd6, 32'd7, lat, bc);
        $display("MULTU 6*7 after reset: lat=%0d HI=%h LO=%h", lat, HI, LO);
        total++; if (lat != 34) begin bad++; $display("FAIL postrst_latency got=%0d want=34", lat); end
        total++; if (LO !== 32'h0000002A) begin bad++; $display("FAIL postrst_lo got=%h want=0000002A", LO); end
        total++; if (HI !== 32'h00000000) begin bad++; $display("FAIL postrst_hi got=%h want=00000000", HI); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_back_to_back();
        test_div_special();
        test_busy_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
